// File: rtl/rom_dump_pkg.sv
// Shared constants, state encoding and frame helpers for the ROM dump sequencer.
package rom_dump_pkg;

    localparam logic [7:0]  FRAME_SYNC  = 8'hA5;
    localparam logic [3:0]  OP_READ     = 4'b1100;
    localparam logic [3:0]  OP_IDLE     = 4'b0000;
    localparam int unsigned FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSample,
        StSend,
        StNext,
        StFinish
    } dump_state_e;

    // Byte idx of a 32-bit frame, MSB-first (idx 0 is the sync byte).
    function automatic logic [7:0] frame_byte(input logic [31:0] frame, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = frame[31:24];
            2'd1:    b = frame[23:16];
            2'd2:    b = frame[15:8];
            default: b = frame[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_frame_serializer.sv
// Holds one 4-byte frame and emits it MSB-first on a registered valid/ready port.
module rom_frame_serializer
    import rom_dump_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] frame,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accepted
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    logic [31:0] frame_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_next;
    logic        valid_q;
    logic [7:0]  data_q;
    logic        accept;

    // Handshake decode; the byte after an accepted one is staged from idx_next.
    always_comb begin
        accept        = valid_q && tx_ready;
        last_accepted = accept && (idx_q == LAST_IDX);
        idx_next      = idx_q + 2'd1;
    end

    // Frame storage and byte stepping; data only changes on load or accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            frame_q <= frame;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= frame_byte(frame, 2'd0);
        end else if (accept) begin
            if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_next;
                data_q <= frame_byte(frame_q, idx_next);
            end
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;

endmodule

// File: rtl/rom_dump_sequencer.sv
// Sweeps every ROM address, waits the settle time, samples data and streams one frame per word.
module rom_dump_sequencer
    import rom_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    input  logic                     tx_ready,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [3:0]               operation,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = '1;

    dump_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]         settle_q;
    logic                     abort_q;
    logic [3:0]               op_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     aborted_q;
    logic                     load;
    logic                     last_accepted;
    logic [31:0]              frame;

    // Frame assembled straight from the pins so SAMPLE captures in a single cycle.
    assign frame = {FRAME_SYNC, 16'(addr_q), 8'(data_line_in)};

    // Next-state decode; the serializer load strobe is issued from SAMPLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle:   if (start) state_d = StSetup;
            StSetup:  if (settle_q == '0) state_d = StSample;
            StSample: begin
                load    = 1'b1;
                state_d = StSend;
            end
            StSend:   if (last_accepted) state_d = StNext;
            StNext:   state_d = (abort_q || addr_q == ADDR_MAX) ? StFinish : StSetup;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, counters and registered outputs; outputs follow state_d so they align with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            settle_q  <= '0;
            abort_q   <= 1'b0;
            op_q      <= OP_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StFinish);
            op_q    <= (state_d == StIdle) ? OP_IDLE : OP_READ;

            if (state_d == StSetup && state_q != StSetup) begin
                settle_q <= SETTLE_LOAD;
            end else if (state_q == StSetup && settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end

            if (state_d == StIdle) begin
                addr_q <= '0;
            end else if (state_q == StNext && state_d == StSetup) begin
                addr_q <= addr_q + 1'b1;
            end

            // A start in IDLE wins over a simultaneous abort.
            if (state_q == StIdle) begin
                if (start) begin
                    abort_q   <= 1'b0;
                    aborted_q <= 1'b0;
                end
            end else if (abort) begin
                abort_q <= 1'b1;
            end

            if (state_d == StFinish) begin
                aborted_q <= abort_q;
            end
        end
    end

    rom_frame_serializer u_serializer (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (load),
        .frame         (frame),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .last_accepted (last_accepted)
    );

    assign address_line = addr_q;
    assign operation    = op_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed bench: an 8-bit and a 4-bit instance with a 3-bit address and 2-cycle settle time.
module tb_rom_dump_sequencer;

    localparam int unsigned AW = 3;
    localparam int unsigned SC = 2;
    localparam int unsigned FULL_CYC = 65;
    localparam int unsigned BUDGET = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start8, abort8, ready8, txv8, busy8, done8, aborted8;
    logic [7:0]    din8, txd8;
    logic [AW-1:0] addr8;
    logic [3:0]    op8;
    logic          start4, abort4, ready4, txv4, busy4, done4, aborted4;
    logic [3:0]    din4;
    logic [7:0]    txd4;
    logic [AW-1:0] addr4;
    logic [3:0]    op4;

    // ROM models
    assign din8 = {5'b0, addr8} ^ 8'h5A;
    assign din4 = 4'hF;

    rom_dump_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(AW), .SETTLE_CYCLES(SC)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .abort(abort8), .data_line_in(din8),
        .tx_ready(ready8), .address_line(addr8), .operation(op8), .tx_data(txd8),
        .tx_valid(txv8), .busy(busy8), .done(done8), .aborted(aborted8)
    );

    rom_dump_sequencer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(AW), .SETTLE_CYCLES(SC)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort4), .data_line_in(din4),
        .tx_ready(ready4), .address_line(addr4), .operation(op4), .tx_data(txd4),
        .tx_valid(txv4), .busy(busy4), .done(done4), .aborted(aborted4)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   exp8;
        logic [31:0]   exp4;
    } vec_t;
    vec_t vecs [8];

    int tests = 0;
    int fails = 0;

    logic [7:0] rx8 [$];
    logic [7:0] rx4 [$];
    bit         stall_pend8 = 0;
    logic [7:0] stall_data8;
    int         stall_cnt8 = 0;
    bit         bp_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Sink monitors: a byte is taken when valid&&ready is seen ahead of the edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_pend8) check("stall hold", {23'b0, txv8, txd8}, {23'b0, 1'b1, stall_data8});
            if (txv8 && ready8) rx8.push_back(txd8);
            if (txv8 && !ready8) stall_cnt8++;
            stall_pend8 = txv8 && !ready8;
            stall_data8 = txd8;
            if (txv4 && ready4) rx4.push_back(txd4);
        end else begin
            stall_pend8 = 0;
        end
    end

    // Sink ready: held high, or ~30% duty in backpressure mode.
    initial begin
        ready8 = 1'b1;
        ready4 = 1'b1;
        forever begin
            @(posedge clk);
            #1 ready8 = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic pulse_start(input bit four, input bit with_abort);
        @(posedge clk);
        #1;
        if (four) start4 = 1'b1; else start8 = 1'b1;
        if (with_abort) abort8 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        abort8 = 1'b0;
    endtask

    // cyc counts edges from the one where start was driven; returns when done is seen.
    task automatic wait_done(input bit four, output int cyc, output logic ab);
        cyc = 1;
        while (!(four ? done4 : done8) && cyc < BUDGET) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("done seen", {31'b0, four ? done4 : done8}, 32'd1);
        ab = four ? aborted4 : aborted8;
    endtask

    task automatic wait_at(input logic [AW-1:0] a, input bit want_valid, output bit ok);
        ok = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            if (busy8 && addr8 == a && txv8 == want_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_frames(input string tag, input bit four, input int nf, input bit exact);
        logic [31:0] got;
        int sz;
        sz = four ? rx4.size() : rx8.size();
        if (exact) check({tag, " byte count"}, sz, 4 * nf);
        else check({tag, " enough bytes"}, {31'b0, sz >= 4 * nf}, 32'd1);
        for (int k = 0; k < nf; k++) begin
            got = 'x;
            if (sz >= 4 * (k + 1)) begin
                if (four) got = {rx4[4*k], rx4[4*k+1], rx4[4*k+2], rx4[4*k+3]};
                else      got = {rx8[4*k], rx8[4*k+1], rx8[4*k+2], rx8[4*k+3]};
            end
            check($sformatf("%s frame %0d", tag, vecs[k].addr), got,
                  four ? vecs[k].exp4 : vecs[k].exp8);
        end
    endtask

    initial begin
        int   cyc;
        logic ab;
        bit   ok;

        vecs[0] = '{3'd0, 32'hA500_005A, 32'hA500_000F};
        vecs[1] = '{3'd1, 32'hA500_015B, 32'hA500_010F};
        vecs[2] = '{3'd2, 32'hA500_0258, 32'hA500_020F};
        vecs[3] = '{3'd3, 32'hA500_0359, 32'hA500_030F};
        vecs[4] = '{3'd4, 32'hA500_045E, 32'hA500_040F};
        vecs[5] = '{3'd5, 32'hA500_055F, 32'hA500_050F};
        vecs[6] = '{3'd6, 32'hA500_065C, 32'hA500_060F};
        vecs[7] = '{3'd7, 32'hA500_075D, 32'hA500_070F};

        reset_n = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; start4 = 1'b0; abort4 = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset outs 8", {addr8, op8, txd8, txv8, busy8, done8, aborted8}, 0);
        check("reset outs 4", {addr4, op4, txd4, txv4, busy4, done4, aborted4}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle 8", {addr8, op8, txd8, txv8, busy8, done8, aborted8}, 0);
            check("idle 4", {addr4, op4, txd4, txv4, busy4, done4, aborted4}, 0);
        end

        // Full sweep, 8-bit
        rx8.delete();
        pulse_start(0, 0);
        check("start busy/op/addr", {busy8, op8, 5'b0, addr8}, {1'b1, 4'b1100, 8'h00});
        wait_done(0, cyc, ab);
        check("sweep cycles", cyc, FULL_CYC);
        check("sweep aborted", {31'b0, ab}, 0);
        @(posedge clk);
        #1;
        check("done one cycle", {done8, busy8, 5'b0, addr8}, 0);
        check_frames("sweep8", 0, 8, 1);

        // Full sweep, 4-bit data
        rx4.delete();
        pulse_start(1, 0);
        wait_done(1, cyc, ab);
        check("sweep4 cycles", cyc, FULL_CYC);
        check_frames("sweep4", 1, 8, 1);

        // Backpressure
        rx8.delete();
        stall_cnt8 = 0;
        bp_mode = 1;
        pulse_start(0, 0);
        wait_done(0, cyc, ab);
        bp_mode = 0;
        check("bp cycles", cyc, FULL_CYC + stall_cnt8);
        check("bp aborted", {31'b0, ab}, 0);
        check_frames("bp", 0, 8, 1);

        // Abort during SEND of address 2
        rx8.delete();
        pulse_start(0, 0);
        wait_at(3'd2, 1'b1, ok);
        check("reach send addr2", {31'b0, ok}, 1);
        abort8 = 1'b1;
        @(posedge clk);
        #1 abort8 = 1'b0;
        wait_done(0, cyc, ab);
        check("abort flag", {31'b0, ab}, 1);
        check_frames("abort", 0, 3, 1);
        @(posedge clk);
        #1;
        check("after abort idle", {busy8, 5'b0, addr8, op8}, 0);
        check("aborted held", {31'b0, aborted8}, 1);

        // Restart with start+abort together: abort ignored
        rx8.delete();
        pulse_start(0, 1);
        check("aborted cleared", {31'b0, aborted8}, 0);
        wait_done(0, cyc, ab);
        check("restart cycles", cyc, FULL_CYC);
        check("restart aborted", {31'b0, ab}, 0);
        check_frames("restart", 0, 8, 1);

        // Stray start while busy, then reset during SEND of address 5
        rx8.delete();
        pulse_start(0, 0);
        wait_at(3'd1, 1'b0, ok);
        check("reach addr1", {31'b0, ok}, 1);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_at(3'd5, 1'b1, ok);
        check("reach send addr5", {31'b0, ok}, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid reset outs", {txv8, busy8, 5'b0, addr8, op8, txd8, done8}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_frames("pre-reset", 0, 5, 0);
        rx8.delete();
        pulse_start(0, 0);
        check("post reset addr", {busy8, 5'b0, addr8}, {1'b1, 8'h00});
        wait_done(0, cyc, ab);
        check("post reset cycles", cyc, FULL_CYC);
        check_frames("post reset", 0, 8, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
